// File: rtl/mtx_pix_packer.sv
// RAW10 transmit packer: 4 pixels per 64-bit word plus FS/FE/LS/LE control entries, buffered in a tagged FIFO.
// Optional build macro MTX_TESTPAT_EN replaces PIX_DATA with an internal 10-bit ramp while TP_ON=1.
module mtx_pix_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [5:0]  DATA_TYPE  = 6'h2B,
  parameter logic [1:0]  VC_ID      = 2'd0
) (
  input  logic        PCK,
  input  logic        RST,
  input  logic        PIX_VSYNC,
  input  logic        PIX_DE,
  input  logic [9:0]  PIX_DATA,
  input  logic        TP_ON,
  input  logic        iMIPI_TX0_READY,
  output logic        oMIPI_TX0_VALID,
  output logic [63:0] oMIPI_TX0_DATA,
  output logic [2:0]  oMIPI_TX0_TAG,
  output logic [5:0]  oMIPI_TX0_TYPE,
  output logic [1:0]  oMIPI_TX0_VC,
  output logic        MTX_OVF,
  output logic [8:0]  MTX_LINE_WORDS
);

  typedef enum logic [2:0] {
    TAG_DATA = 3'd0,
    TAG_FS   = 3'd1,
    TAG_FE   = 3'd2,
    TAG_LS   = 3'd3,
    TAG_LE   = 3'd4
  } tag_e;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // ---------------------------------------------------------------- timing edges
  logic vs_q, de_q;
  // An edge only counts once its input has been seen low since reset, so a
  // reset in the middle of a frame or line never fakes a start event.
  logic vs_armed, de_armed;
  logic vs_rise, vs_fall, de_rise, de_fall, pix_acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge PCK) begin
    if (RST) begin
      vs_q     <= 1'b0;
      de_q     <= 1'b0;
      vs_armed <= 1'b0;
      de_armed <= 1'b0;
    end else begin
      vs_q <= PIX_VSYNC;
      de_q <= PIX_DE;
      if (!PIX_VSYNC) vs_armed <= 1'b1;
      if (!PIX_DE)    de_armed <= 1'b1;
    end
  end

  assign vs_rise = PIX_VSYNC  & ~vs_q & vs_armed;
  assign vs_fall = ~PIX_VSYNC & vs_q  & vs_armed;
  assign de_rise = PIX_DE     & ~de_q & de_armed;
  assign de_fall = ~PIX_DE    & de_q  & de_armed;
  assign pix_acc = PIX_DE & de_armed;

  // ---------------------------------------------------------------- pixel source
  logic [9:0] pix_val;

`ifdef MTX_TESTPAT_EN
  logic [9:0] ramp;
  logic [9:0] ramp_cur;

  assign ramp_cur = de_rise ? 10'd0 : ramp;
  assign pix_val  = TP_ON ? ramp_cur : PIX_DATA;

  always_ff @(posedge PCK) begin
    if (RST) begin
      ramp <= 10'd0;
    end else if (pix_acc) begin
      ramp <= ramp_cur + 10'd1;
    end
  end
`else
  logic unused_tp_on;
  assign unused_tp_on = TP_ON;
  assign pix_val      = PIX_DATA;
`endif

  // ---------------------------------------------------------------- packing
  logic [1:0]  slot;
  logic [39:0] shadow, shadow_ins, data_word;

  // NOTE: every always_comb output gets a default first so no path can hold
  // an old value and infer a latch.
  always_comb begin
    shadow_ins = shadow;
    unique case (slot)
      2'd0: begin shadow_ins[15:8]  = pix_val[9:2]; shadow_ins[1:0] = pix_val[1:0]; end
      2'd1: begin shadow_ins[23:16] = pix_val[9:2]; shadow_ins[3:2] = pix_val[1:0]; end
      2'd2: begin shadow_ins[31:24] = pix_val[9:2]; shadow_ins[5:4] = pix_val[1:0]; end
      2'd3: begin shadow_ins[39:32] = pix_val[9:2]; shadow_ins[7:6] = pix_val[1:0]; end
    endcase
  end

  logic set_data;
  assign set_data = (pix_acc && slot == 2'd3) || (!pix_acc && de_fall && slot != 2'd0);

  always_ff @(posedge PCK) begin
    if (RST) begin
      slot      <= 2'd0;
      shadow    <= '0;
      data_word <= '0;
    end else if (pix_acc) begin
      slot <= slot + 2'd1;
      if (slot == 2'd3) begin
        data_word <= shadow_ins;
        shadow    <= '0;
      end else begin
        shadow <= shadow_ins;
      end
    end else if (de_fall && slot != 2'd0) begin
      data_word <= shadow;
      shadow    <= '0;
      slot      <= 2'd0;
    end
  end

  // ---------------------------------------------------------------- pending events and push arbitration
  logic pend_data, pend_fs, pend_fe, pend_ls, pend_le;
  logic gnt_data, gnt_fs, gnt_fe, gnt_ls, gnt_le;
  logic        push;
  tag_e        push_tag;
  logic [63:0] push_data;

  always_comb begin
    push      = 1'b0;
    push_tag  = TAG_DATA;
    push_data = '0;
    gnt_data  = 1'b0;
    gnt_fs    = 1'b0;
    gnt_fe    = 1'b0;
    gnt_ls    = 1'b0;
    gnt_le    = 1'b0;
    if (pend_ls) begin
      push = 1'b1; push_tag = TAG_LS; gnt_ls = 1'b1;
    end else if (pend_data) begin
      push = 1'b1; push_tag = TAG_DATA; gnt_data = 1'b1;
      push_data = {24'd0, data_word};
    end else if (pend_le) begin
      push = 1'b1; push_tag = TAG_LE; gnt_le = 1'b1;
    end else if (pend_fs) begin
      push = 1'b1; push_tag = TAG_FS; gnt_fs = 1'b1;
    end else if (pend_fe) begin
      push = 1'b1; push_tag = TAG_FE; gnt_fe = 1'b1;
    end
  end

  // A flag set in the same cycle its previous instance is granted stays set.
  always_ff @(posedge PCK) begin
    if (RST) begin
      pend_data <= 1'b0;
      pend_fs   <= 1'b0;
      pend_fe   <= 1'b0;
      pend_ls   <= 1'b0;
      pend_le   <= 1'b0;
    end else begin
      pend_data <= set_data | (pend_data & ~gnt_data);
      pend_fs   <= vs_rise  | (pend_fs   & ~gnt_fs);
      pend_fe   <= vs_fall  | (pend_fe   & ~gnt_fe);
      pend_ls   <= de_rise  | (pend_ls   & ~gnt_ls);
      pend_le   <= de_fall  | (pend_le   & ~gnt_le);
    end
  end

  // ---------------------------------------------------------------- tagged FIFO
  logic [66:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr_en, drop;
  logic [66:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & iMIPI_TX0_READY;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // NOTE: the storage array has no reset; only the pointers do, and the
  // head is masked while empty so stale contents never reach the outputs.
  always_ff @(posedge PCK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {push_tag, push_data};
  end

  always_ff @(posedge PCK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign head            = mem[rd_ptr[AW-1:0]];
  assign oMIPI_TX0_VALID = ~empty;
  assign oMIPI_TX0_DATA  = empty ? 64'd0 : head[63:0];
  assign oMIPI_TX0_TAG   = empty ? 3'd0  : head[66:64];
  assign oMIPI_TX0_TYPE  = DATA_TYPE;
  assign oMIPI_TX0_VC    = VC_ID;

  // ---------------------------------------------------------------- status
  logic [8:0] word_cnt;

  always_ff @(posedge PCK) begin
    if (RST) begin
      MTX_OVF        <= 1'b0;
      word_cnt       <= 9'd0;
      MTX_LINE_WORDS <= 9'd0;
    end else begin
      if (drop)                                 MTX_OVF <= 1'b1;
      else if (wr_en && push_tag == TAG_FS)     MTX_OVF <= 1'b0;

      if (wr_en && push_tag == TAG_LS)          word_cnt <= 9'd0;
      else if (wr_en && push_tag == TAG_DATA && word_cnt != 9'd511)
                                                word_cnt <= word_cnt + 9'd1;

      if (wr_en && push_tag == TAG_LE)          MTX_LINE_WORDS <= word_cnt;
    end
  end

endmodule

// File: tb/tb_mtx_pix_packer.sv
// Directed bench for mtx_pix_packer: popped entries are collected and compared with hand-packed words.
module tb_mtx_pix_packer;

  logic        PCK = 1'b0;
  logic        RST, PIX_VSYNC, PIX_DE, TP_ON, iMIPI_TX0_READY;
  logic [9:0]  PIX_DATA;
  logic        oMIPI_TX0_VALID;
  logic [63:0] oMIPI_TX0_DATA;
  logic [2:0]  oMIPI_TX0_TAG;
  logic [5:0]  oMIPI_TX0_TYPE;
  logic [1:0]  oMIPI_TX0_VC;
  logic        MTX_OVF;
  logic [8:0]  MTX_LINE_WORDS;

  mtx_pix_packer dut (
    .PCK             (PCK),
    .RST             (RST),
    .PIX_VSYNC       (PIX_VSYNC),
    .PIX_DE          (PIX_DE),
    .PIX_DATA        (PIX_DATA),
    .TP_ON           (TP_ON),
    .iMIPI_TX0_READY (iMIPI_TX0_READY),
    .oMIPI_TX0_VALID (oMIPI_TX0_VALID),
    .oMIPI_TX0_DATA  (oMIPI_TX0_DATA),
    .oMIPI_TX0_TAG   (oMIPI_TX0_TAG),
    .oMIPI_TX0_TYPE  (oMIPI_TX0_TYPE),
    .oMIPI_TX0_VC    (oMIPI_TX0_VC),
    .MTX_OVF         (MTX_OVF),
    .MTX_LINE_WORDS  (MTX_LINE_WORDS)
  );

  always #5 PCK = ~PCK;

  localparam logic [2:0] T_DATA = 3'd0, T_FS = 3'd1, T_FE = 3'd2, T_LS = 3'd3, T_LE = 3'd4;
  // Hand-packed words: byte0 = four 2-bit LSB fields, bytes 1..4 = pixel MSBs of slots 0..3.
  localparam logic [63:0] W_A    = 64'h0000_0055_AA00_FF67; // 3FF,001,2AA,155
  localparam logic [63:0] W_B    = 64'h0000_00B7_48C3_3C3C; // 0F0,30F,123,2DC
  localparam logic [63:0] W_4    = 64'h0000_0001_0101_0100; // 004 x4
  localparam logic [63:0] W_4P   = 64'h0000_0000_0001_0100; // 004 x2, slots 2,3 empty
  localparam logic [63:0] W_TP   = 64'h0000_0000_0000_00E4; // ramp 0,1,2,3
  localparam logic [63:0] W_ONES = 64'h0000_00FF_FFFF_FFFF; // 3FF x4

  logic [9:0] line_tbl [8] = '{10'h3FF, 10'h001, 10'h2AA, 10'h155,
                               10'h0F0, 10'h30F, 10'h123, 10'h2DC};

  logic       s_rst, s_vs, s_de, s_tp;
  logic [9:0] s_px;
  int         rdy_mode;   // 0 = stalled, 1 = always ready, 2 = toggle every cycle
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [66:0] cap_q [$];
  logic [66:0] exp_q [$];

  task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [66:0] ent(input logic [2:0] t, input logic [63:0] d);
    return {t, d};
  endfunction

  // Drive staged inputs at the falling edge, then record a pop if this cycle hands one over.
  task automatic tick();
    @(negedge PCK);
    RST       = s_rst;
    PIX_VSYNC = s_vs;
    PIX_DE    = s_de;
    PIX_DATA  = s_px;
    TP_ON     = s_tp;
    case (rdy_mode)
      0:       iMIPI_TX0_READY = 1'b0;
      1:       iMIPI_TX0_READY = 1'b1;
      default: iMIPI_TX0_READY = ~iMIPI_TX0_READY;
    endcase
    #1;
    if (oMIPI_TX0_VALID && iMIPI_TX0_READY)
      cap_q.push_back({oMIPI_TX0_TAG, oMIPI_TX0_DATA});
  endtask

  task automatic idle(input int n);
    s_de = 1'b0;
    s_px = 10'd0;
    repeat (n) tick();
  endtask

  task automatic send_line(input int n, input bit use_tbl, input logic [9:0] val);
    for (int i = 0; i < n; i++) begin
      s_de = 1'b1;
      s_px = use_tbl ? line_tbl[i % 8] : val;
      tick();
    end
    s_de = 1'b0;
    s_px = 10'd0;
  endtask

  task automatic compare_q(input string name);
    logic [66:0] got;
    check({name, "_count"}, 67'(cap_q.size()), 67'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : '1;
      check($sformatf("%s[%0d]", name, i), got, exp_q[i]);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic frame_2x8(input int drain);
    s_vs = 1'b1;
    idle(2);
    send_line(8, 1'b1, 10'd0);
    idle(4);
    send_line(8, 1'b1, 10'd0);
    idle(3);
    s_vs = 1'b0;
    idle(drain);
  endtask

  task automatic expect_frame_2x8();
    exp_q.push_back(ent(T_FS, 64'd0));
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back(ent(T_LS, 64'd0));
      exp_q.push_back(ent(T_DATA, W_A));
      exp_q.push_back(ent(T_DATA, W_B));
      exp_q.push_back(ent(T_LE, 64'd0));
    end
    exp_q.push_back(ent(T_FE, 64'd0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; PIX_VSYNC = 1'b0; PIX_DE = 1'b0; PIX_DATA = 10'd0; TP_ON = 1'b0;
    iMIPI_TX0_READY = 1'b1;
    s_rst = 1'b1; s_vs = 1'b0; s_de = 1'b0; s_px = 10'd0; s_tp = 1'b0;
    rdy_mode = 1;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 67'(oMIPI_TX0_VALID), 67'(0));
    check("rst_data",  67'(oMIPI_TX0_DATA),  67'(0));
    check("rst_tag",   67'(oMIPI_TX0_TAG),   67'(0));
    check("rst_ovf",   67'(MTX_OVF),         67'(0));
    check("rst_words", 67'(MTX_LINE_WORDS),  67'(0));
    check("type",      67'(oMIPI_TX0_TYPE),  67'(6'h2B));
    check("vc",        67'(oMIPI_TX0_VC),    67'(0));
    s_rst = 1'b0;
    idle(3);

    // Two-line frame, always ready
    rdy_mode = 1;
    frame_2x8(10);
    expect_frame_2x8();
    compare_q("frame");
    check("frame_words", 67'(MTX_LINE_WORDS), 67'(2));

    // Six-pixel short line, with first-word latency
    s_de = 1'b1; s_px = 10'h004;
    repeat (4) tick();
    tick();
    check("lat_n1_valid", 67'(oMIPI_TX0_VALID), 67'(0));
    tick();
    check("lat_n2_valid", 67'(oMIPI_TX0_VALID), 67'(1));
    check("lat_n2_tag",   67'(oMIPI_TX0_TAG),   67'(T_DATA));
    check("lat_n2_data",  67'(oMIPI_TX0_DATA),  67'(W_4));
    idle(6);
    exp_q.push_back(ent(T_LS, 64'd0));
    exp_q.push_back(ent(T_DATA, W_4));
    exp_q.push_back(ent(T_DATA, W_4P));
    exp_q.push_back(ent(T_LE, 64'd0));
    compare_q("short");
    check("short_words", 67'(MTX_LINE_WORDS), 67'(2));

    // Stall: FIFO fills, entries drop, OVF cleared by the next FS push
    rdy_mode = 0;
    s_vs = 1'b1;
    idle(2);
    send_line(16, 1'b1, 10'd0);
    idle(4);
    check("stall1_ovf",  67'(MTX_OVF),         67'(0));
    check("stall1_head", {oMIPI_TX0_TAG, oMIPI_TX0_DATA}, ent(T_FS, 64'd0));
    send_line(8, 1'b1, 10'd0);
    idle(4);
    check("stall2_ovf",   67'(MTX_OVF),         67'(1));
    check("stall2_valid", 67'(oMIPI_TX0_VALID), 67'(1));
    check("stall2_head",  {oMIPI_TX0_TAG, oMIPI_TX0_DATA}, ent(T_FS, 64'd0));
    rdy_mode = 1;
    idle(12);
    check("ovf_words",      67'(MTX_LINE_WORDS), 67'(4));
    check("ovf_after_drain", 67'(MTX_OVF),       67'(1));
    s_vs = 1'b0;
    idle(4);
    check("ovf_after_fe", 67'(MTX_OVF), 67'(1));
    s_vs = 1'b1;
    idle(3);
    check("ovf_after_fs", 67'(MTX_OVF), 67'(0));
    s_vs = 1'b0;
    idle(4);
    exp_q.push_back(ent(T_FS, 64'd0));
    exp_q.push_back(ent(T_LS, 64'd0));
    exp_q.push_back(ent(T_DATA, W_A));
    exp_q.push_back(ent(T_DATA, W_B));
    exp_q.push_back(ent(T_DATA, W_A));
    exp_q.push_back(ent(T_DATA, W_B));
    exp_q.push_back(ent(T_LE, 64'd0));
    exp_q.push_back(ent(T_LS, 64'd0));
    exp_q.push_back(ent(T_FE, 64'd0));
    exp_q.push_back(ent(T_FS, 64'd0));
    exp_q.push_back(ent(T_FE, 64'd0));
    compare_q("ovf");

    // READY toggling every cycle
    rdy_mode = 2;
    frame_2x8(30);
    expect_frame_2x8();
    compare_q("toggle");
    check("toggle_words", 67'(MTX_LINE_WORDS), 67'(2));

    // Reset on the third pixel of a line
    rdy_mode = 1;
    s_de = 1'b1; s_px = 10'h004;
    tick();
    tick();
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    tick();
    check("mid_rst_valid", 67'(oMIPI_TX0_VALID), 67'(0));
    check("mid_rst_data",  67'(oMIPI_TX0_DATA),  67'(0));
    check("mid_rst_tag",   67'(oMIPI_TX0_TAG),   67'(0));
    check("mid_rst_ovf",   67'(MTX_OVF),         67'(0));
    check("mid_rst_words", 67'(MTX_LINE_WORDS),  67'(0));
    cap_q.delete();
    repeat (4) tick();
    idle(4);
    send_line(4, 1'b0, 10'h004);
    idle(6);
    exp_q.push_back(ent(T_LS, 64'd0));
    exp_q.push_back(ent(T_DATA, W_4));
    exp_q.push_back(ent(T_LE, 64'd0));
    compare_q("after_rst");
    check("after_rst_words", 67'(MTX_LINE_WORDS), 67'(1));

    // Test-pattern select
    s_tp = 1'b1;
    send_line(4, 1'b0, 10'h3FF);
    idle(6);
    s_tp = 1'b0;
    exp_q.push_back(ent(T_LS, 64'd0));
`ifdef MTX_TESTPAT_EN
    exp_q.push_back(ent(T_DATA, W_TP));
`else
    exp_q.push_back(ent(T_DATA, W_ONES));
`endif
    exp_q.push_back(ent(T_LE, 64'd0));
    compare_q("testpat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
